// File: rtl/armleocpu_axi_rr_arbiter_pkg.sv
// Shared types and helpers for the N-to-1 AXI4 round-robin arbiter.
package armleocpu_axi_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    // Pointer width that stays legal for a single host
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/armleocpu_rr_arbiter_core.sv
// Grant register plus rotating pointer; fixed priority when OPT_PRIORITY_MODE=1.
module armleocpu_rr_arbiter_core
    import armleocpu_axi_rr_arbiter_pkg::*;
#(
    parameter int unsigned N                 = 2,
    parameter int unsigned OPT_PRIORITY_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    input  logic         complete,
    output logic [N-1:0] grant_onehot
);

    localparam int unsigned    PTR_W = ptr_width(N);
    localparam logic [N-1:0]   ONES  = '1;
    localparam logic [N-1:0]   ONE_N = N'(1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [N-1:0]     mask, hi, cand, pick;

    // First request at or above the pointer, else first request overall
    always_comb begin : pick_winner
        mask = ONES << ptr_q;
        hi   = req & mask;
        cand = (|hi) ? hi : req;
        pick = cand & (~cand + ONE_N);
    end

    always_comb begin : next_grant
        grant_d = grant_q;
        if (advance) begin
            grant_d = pick;
        end
    end

    // Pointer moves just past the host that finished; wraps to 0 after N-1
    always_comb begin : next_ptr
        ptr_d = ptr_q;
        if (OPT_PRIORITY_MODE != 0) begin
            ptr_d = '0;
        end else if (complete) begin
            ptr_d = '0;
            for (int unsigned i = 0; i + 1 < N; i++) begin
                if (grant_q[i]) begin
                    ptr_d = PTR_W'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : regs
        if (rst) begin
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign grant_onehot = grant_q;

endmodule

// File: rtl/armleocpu_axi_rr_arbiter.sv
// N-to-1 AXI4 arbiter: independent read/write FSMs, one burst in flight per direction.
module armleocpu_axi_rr_arbiter
    import armleocpu_axi_rr_arbiter_pkg::*;
#(
    parameter int unsigned OPT_NUMBER_OF_HOSTS = 2,
    parameter int unsigned ADDR_WIDTH          = 34,
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned ID_WIDTH            = 4,
    parameter int unsigned OPT_PRIORITY_MODE   = 0
) (
    input  logic                                            clk,
    input  logic                                            rst,

    input  logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_awvalid,
    output logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_awready,
    input  logic [OPT_NUMBER_OF_HOSTS*ADDR_WIDTH-1:0]       upstream_axi_awaddr,
    input  logic [OPT_NUMBER_OF_HOSTS*8-1:0]                upstream_axi_awlen,
    input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]                upstream_axi_awsize,
    input  logic [OPT_NUMBER_OF_HOSTS*2-1:0]                upstream_axi_awburst,
    input  logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0]         upstream_axi_awid,
    input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]                upstream_axi_awprot,

    input  logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_wvalid,
    output logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_wready,
    input  logic [OPT_NUMBER_OF_HOSTS*DATA_WIDTH-1:0]       upstream_axi_wdata,
    input  logic [OPT_NUMBER_OF_HOSTS*(DATA_WIDTH/8)-1:0]   upstream_axi_wstrb,
    input  logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_wlast,

    output logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_bvalid,
    input  logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_bready,
    output logic [OPT_NUMBER_OF_HOSTS*2-1:0]                upstream_axi_bresp,
    output logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0]         upstream_axi_bid,

    input  logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_arvalid,
    output logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_arready,
    input  logic [OPT_NUMBER_OF_HOSTS*ADDR_WIDTH-1:0]       upstream_axi_araddr,
    input  logic [OPT_NUMBER_OF_HOSTS*8-1:0]                upstream_axi_arlen,
    input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]                upstream_axi_arsize,
    input  logic [OPT_NUMBER_OF_HOSTS*2-1:0]                upstream_axi_arburst,
    input  logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0]         upstream_axi_arid,
    input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]                upstream_axi_arprot,

    output logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_rvalid,
    input  logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_rready,
    output logic [OPT_NUMBER_OF_HOSTS*DATA_WIDTH-1:0]       upstream_axi_rdata,
    output logic [OPT_NUMBER_OF_HOSTS*2-1:0]                upstream_axi_rresp,
    output logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0]         upstream_axi_rid,
    output logic [OPT_NUMBER_OF_HOSTS-1:0]                  upstream_axi_rlast,

    output logic                                            downstream_axi_awvalid,
    input  logic                                            downstream_axi_awready,
    output logic [ADDR_WIDTH-1:0]                           downstream_axi_awaddr,
    output logic [7:0]                                      downstream_axi_awlen,
    output logic [2:0]                                      downstream_axi_awsize,
    output logic [1:0]                                      downstream_axi_awburst,
    output logic [ID_WIDTH-1:0]                             downstream_axi_awid,
    output logic [2:0]                                      downstream_axi_awprot,

    output logic                                            downstream_axi_wvalid,
    input  logic                                            downstream_axi_wready,
    output logic [DATA_WIDTH-1:0]                           downstream_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]                         downstream_axi_wstrb,
    output logic                                            downstream_axi_wlast,

    input  logic                                            downstream_axi_bvalid,
    output logic                                            downstream_axi_bready,
    input  logic [1:0]                                      downstream_axi_bresp,
    input  logic [ID_WIDTH-1:0]                             downstream_axi_bid,

    output logic                                            downstream_axi_arvalid,
    input  logic                                            downstream_axi_arready,
    output logic [ADDR_WIDTH-1:0]                           downstream_axi_araddr,
    output logic [7:0]                                      downstream_axi_arlen,
    output logic [2:0]                                      downstream_axi_arsize,
    output logic [1:0]                                      downstream_axi_arburst,
    output logic [ID_WIDTH-1:0]                             downstream_axi_arid,
    output logic [2:0]                                      downstream_axi_arprot,

    input  logic                                            downstream_axi_rvalid,
    output logic                                            downstream_axi_rready,
    input  logic [DATA_WIDTH-1:0]                           downstream_axi_rdata,
    input  logic [1:0]                                      downstream_axi_rresp,
    input  logic [ID_WIDTH-1:0]                             downstream_axi_rid,
    input  logic                                            downstream_axi_rlast
);

    localparam int unsigned N      = OPT_NUMBER_OF_HOSTS;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    w_state_t     w_state_q, w_state_d;
    r_state_t     r_state_q, r_state_d;
    logic [N-1:0] w_grant, r_grant;
    logic         w_advance, w_complete, r_advance, r_complete;
    logic         aw_sel_valid, w_sel_valid, b_sel_ready, ar_sel_valid, r_sel_ready;

    armleocpu_rr_arbiter_core #(
        .N                 (N),
        .OPT_PRIORITY_MODE (OPT_PRIORITY_MODE)
    ) u_w_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (upstream_axi_awvalid),
        .advance      (w_advance),
        .complete     (w_complete),
        .grant_onehot (w_grant)
    );

    armleocpu_rr_arbiter_core #(
        .N                 (N),
        .OPT_PRIORITY_MODE (OPT_PRIORITY_MODE)
    ) u_r_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (upstream_axi_arvalid),
        .advance      (r_advance),
        .complete     (r_complete),
        .grant_onehot (r_grant)
    );

    assign aw_sel_valid = |(upstream_axi_awvalid & w_grant);
    assign w_sel_valid  = |(upstream_axi_wvalid  & w_grant);
    assign b_sel_ready  = |(upstream_axi_bready  & w_grant);
    assign ar_sel_valid = |(upstream_axi_arvalid & r_grant);
    assign r_sel_ready  = |(upstream_axi_rready  & r_grant);

    // Response payloads are broadcast; only the owner's valid is raised
    assign upstream_axi_bresp = {N{downstream_axi_bresp}};
    assign upstream_axi_bid   = {N{downstream_axi_bid}};
    assign upstream_axi_rdata = {N{downstream_axi_rdata}};
    assign upstream_axi_rresp = {N{downstream_axi_rresp}};
    assign upstream_axi_rid   = {N{downstream_axi_rid}};
    assign upstream_axi_rlast = {N{downstream_axi_rlast}};

    // One-hot AND-OR payload muxes keyed directly by the grant registers
    always_comb begin : aw_mux
        downstream_axi_awaddr  = '0;
        downstream_axi_awlen   = '0;
        downstream_axi_awsize  = '0;
        downstream_axi_awburst = '0;
        downstream_axi_awid    = '0;
        downstream_axi_awprot  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            downstream_axi_awaddr  |= upstream_axi_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{w_grant[i]}};
            downstream_axi_awlen   |= upstream_axi_awlen[i*8 +: 8]                    & {8{w_grant[i]}};
            downstream_axi_awsize  |= upstream_axi_awsize[i*3 +: 3]                   & {3{w_grant[i]}};
            downstream_axi_awburst |= upstream_axi_awburst[i*2 +: 2]                  & {2{w_grant[i]}};
            downstream_axi_awid    |= upstream_axi_awid[i*ID_WIDTH +: ID_WIDTH]       & {ID_WIDTH{w_grant[i]}};
            downstream_axi_awprot  |= upstream_axi_awprot[i*3 +: 3]                   & {3{w_grant[i]}};
        end
    end

    always_comb begin : w_mux
        downstream_axi_wdata = '0;
        downstream_axi_wstrb = '0;
        downstream_axi_wlast = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            downstream_axi_wdata |= upstream_axi_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant[i]}};
            downstream_axi_wstrb |= upstream_axi_wstrb[i*STRB_W +: STRB_W]         & {STRB_W{w_grant[i]}};
            downstream_axi_wlast |= upstream_axi_wlast[i] & w_grant[i];
        end
    end

    always_comb begin : ar_mux
        downstream_axi_araddr  = '0;
        downstream_axi_arlen   = '0;
        downstream_axi_arsize  = '0;
        downstream_axi_arburst = '0;
        downstream_axi_arid    = '0;
        downstream_axi_arprot  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            downstream_axi_araddr  |= upstream_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{r_grant[i]}};
            downstream_axi_arlen   |= upstream_axi_arlen[i*8 +: 8]                    & {8{r_grant[i]}};
            downstream_axi_arsize  |= upstream_axi_arsize[i*3 +: 3]                   & {3{r_grant[i]}};
            downstream_axi_arburst |= upstream_axi_arburst[i*2 +: 2]                  & {2{r_grant[i]}};
            downstream_axi_arid    |= upstream_axi_arid[i*ID_WIDTH +: ID_WIDTH]       & {ID_WIDTH{r_grant[i]}};
            downstream_axi_arprot  |= upstream_axi_arprot[i*3 +: 3]                   & {3{r_grant[i]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin : state_regs
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    // Write FSM: grant in IDLE, then AW, W until wlast, B to the owner only
    always_comb begin : w_fsm
        w_state_d              = w_state_q;
        w_advance              = 1'b0;
        w_complete             = 1'b0;
        downstream_axi_awvalid = 1'b0;
        downstream_axi_wvalid  = 1'b0;
        downstream_axi_bready  = 1'b0;
        upstream_axi_awready   = '0;
        upstream_axi_wready    = '0;
        upstream_axi_bvalid    = '0;
        case (w_state_q)
            W_IDLE: begin
                if (|upstream_axi_awvalid) begin
                    w_advance = 1'b1;
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                downstream_axi_awvalid = aw_sel_valid;
                upstream_axi_awready   = w_grant & {N{downstream_axi_awready}};
                if (aw_sel_valid && downstream_axi_awready) begin
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                downstream_axi_wvalid = w_sel_valid;
                upstream_axi_wready   = w_grant & {N{downstream_axi_wready}};
                if (w_sel_valid && downstream_axi_wready && downstream_axi_wlast) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                downstream_axi_bready = b_sel_ready;
                upstream_axi_bvalid   = w_grant & {N{downstream_axi_bvalid}};
                if (downstream_axi_bvalid && b_sel_ready) begin
                    w_complete = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: grant in IDLE, then AR, R beats to the owner until rlast
    always_comb begin : r_fsm
        r_state_d              = r_state_q;
        r_advance              = 1'b0;
        r_complete             = 1'b0;
        downstream_axi_arvalid = 1'b0;
        downstream_axi_rready  = 1'b0;
        upstream_axi_arready   = '0;
        upstream_axi_rvalid    = '0;
        case (r_state_q)
            R_IDLE: begin
                if (|upstream_axi_arvalid) begin
                    r_advance = 1'b1;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                downstream_axi_arvalid = ar_sel_valid;
                upstream_axi_arready   = r_grant & {N{downstream_axi_arready}};
                if (ar_sel_valid && downstream_axi_arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                downstream_axi_rready = r_sel_ready;
                upstream_axi_rvalid   = r_grant & {N{downstream_axi_rvalid}};
                if (downstream_axi_rvalid && r_sel_ready && downstream_axi_rlast) begin
                    r_complete = 1'b1;
                    r_state_d  = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_armleocpu_axi_rr_arbiter.sv
// Directed bench: a round-robin instance [0] and a fixed-priority instance [1] share all inputs.
module tb_armleocpu_axi_rr_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned A = 34;
    localparam int unsigned D = 32;
    localparam int unsigned I = 4;
    localparam int unsigned S = D / 8;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]   up_awvalid, up_wvalid, up_wlast, up_bready, up_arvalid, up_rready;
    logic [N*A-1:0] up_awaddr, up_araddr;
    logic [N*8-1:0] up_awlen, up_arlen;
    logic [N*3-1:0] up_awsize, up_awprot, up_arsize, up_arprot;
    logic [N*2-1:0] up_awburst, up_arburst;
    logic [N*I-1:0] up_awid, up_arid;
    logic [N*D-1:0] up_wdata;
    logic [N*S-1:0] up_wstrb;

    logic           ds_awready, ds_wready, ds_bvalid, ds_arready, ds_rvalid, ds_rlast;
    logic [1:0]     ds_bresp, ds_rresp;
    logic [I-1:0]   ds_bid, ds_rid;
    logic [D-1:0]   ds_rdata;

    logic [N-1:0]   o_awready [2], o_wready [2], o_bvalid [2], o_arready [2], o_rvalid [2], o_rlast [2];
    logic [N*2-1:0] o_bresp [2], o_rresp [2];
    logic [N*I-1:0] o_bid [2], o_rid [2];
    logic [N*D-1:0] o_rdata [2];
    logic           o_ds_awvalid [2], o_ds_wvalid [2], o_ds_wlast [2];
    logic           o_ds_bready [2], o_ds_arvalid [2], o_ds_rready [2];
    logic [A-1:0]   o_ds_awaddr [2], o_ds_araddr [2];
    logic [7:0]     o_ds_awlen [2], o_ds_arlen [2];
    logic [2:0]     o_ds_awsize [2], o_ds_awprot [2], o_ds_arsize [2], o_ds_arprot [2];
    logic [1:0]     o_ds_awburst [2], o_ds_arburst [2];
    logic [I-1:0]   o_ds_awid [2], o_ds_arid [2];
    logic [D-1:0]   o_ds_wdata [2];
    logic [S-1:0]   o_ds_wstrb [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        armleocpu_axi_rr_arbiter #(
            .OPT_NUMBER_OF_HOSTS (N),
            .ADDR_WIDTH          (A),
            .DATA_WIDTH          (D),
            .ID_WIDTH            (I),
            .OPT_PRIORITY_MODE   (g)
        ) u_dut (
            .clk                    (clk),
            .rst                    (rst),
            .upstream_axi_awvalid   (up_awvalid),
            .upstream_axi_awready   (o_awready[g]),
            .upstream_axi_awaddr    (up_awaddr),
            .upstream_axi_awlen     (up_awlen),
            .upstream_axi_awsize    (up_awsize),
            .upstream_axi_awburst   (up_awburst),
            .upstream_axi_awid      (up_awid),
            .upstream_axi_awprot    (up_awprot),
            .upstream_axi_wvalid    (up_wvalid),
            .upstream_axi_wready    (o_wready[g]),
            .upstream_axi_wdata     (up_wdata),
            .upstream_axi_wstrb     (up_wstrb),
            .upstream_axi_wlast     (up_wlast),
            .upstream_axi_bvalid    (o_bvalid[g]),
            .upstream_axi_bready    (up_bready),
            .upstream_axi_bresp     (o_bresp[g]),
            .upstream_axi_bid       (o_bid[g]),
            .upstream_axi_arvalid   (up_arvalid),
            .upstream_axi_arready   (o_arready[g]),
            .upstream_axi_araddr    (up_araddr),
            .upstream_axi_arlen     (up_arlen),
            .upstream_axi_arsize    (up_arsize),
            .upstream_axi_arburst   (up_arburst),
            .upstream_axi_arid      (up_arid),
            .upstream_axi_arprot    (up_arprot),
            .upstream_axi_rvalid    (o_rvalid[g]),
            .upstream_axi_rready    (up_rready),
            .upstream_axi_rdata     (o_rdata[g]),
            .upstream_axi_rresp     (o_rresp[g]),
            .upstream_axi_rid       (o_rid[g]),
            .upstream_axi_rlast     (o_rlast[g]),
            .downstream_axi_awvalid (o_ds_awvalid[g]),
            .downstream_axi_awready (ds_awready),
            .downstream_axi_awaddr  (o_ds_awaddr[g]),
            .downstream_axi_awlen   (o_ds_awlen[g]),
            .downstream_axi_awsize  (o_ds_awsize[g]),
            .downstream_axi_awburst (o_ds_awburst[g]),
            .downstream_axi_awid    (o_ds_awid[g]),
            .downstream_axi_awprot  (o_ds_awprot[g]),
            .downstream_axi_wvalid  (o_ds_wvalid[g]),
            .downstream_axi_wready  (ds_wready),
            .downstream_axi_wdata   (o_ds_wdata[g]),
            .downstream_axi_wstrb   (o_ds_wstrb[g]),
            .downstream_axi_wlast   (o_ds_wlast[g]),
            .downstream_axi_bvalid  (ds_bvalid),
            .downstream_axi_bready  (o_ds_bready[g]),
            .downstream_axi_bresp   (ds_bresp),
            .downstream_axi_bid     (ds_bid),
            .downstream_axi_arvalid (o_ds_arvalid[g]),
            .downstream_axi_arready (ds_arready),
            .downstream_axi_araddr  (o_ds_araddr[g]),
            .downstream_axi_arlen   (o_ds_arlen[g]),
            .downstream_axi_arsize  (o_ds_arsize[g]),
            .downstream_axi_arburst (o_ds_arburst[g]),
            .downstream_axi_arid    (o_ds_arid[g]),
            .downstream_axi_arprot  (o_ds_arprot[g]),
            .downstream_axi_rvalid  (ds_rvalid),
            .downstream_axi_rready  (o_ds_rready[g]),
            .downstream_axi_rdata   (ds_rdata),
            .downstream_axi_rresp   (ds_rresp),
            .downstream_axi_rid     (ds_rid),
            .downstream_axi_rlast   (ds_rlast)
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        up_awvalid = '0; up_wvalid = '0; up_wlast = '0; up_bready = '0; up_arvalid = '0; up_rready = '0;
        up_awaddr = '0; up_araddr = '0; up_awlen = '0; up_arlen = '0;
        up_awsize = '0; up_awprot = '0; up_arsize = '0; up_arprot = '0;
        up_awburst = '0; up_arburst = '0; up_awid = '0; up_arid = '0;
        up_wdata = '0; up_wstrb = '0;
        ds_awready = 1'b0; ds_wready = 1'b0; ds_bvalid = 1'b0; ds_arready = 1'b0;
        ds_rvalid = 1'b0; ds_rlast = 1'b0; ds_bresp = '0; ds_rresp = '0;
        ds_bid = '0; ds_rid = '0; ds_rdata = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One single-beat write burst; checks which host each instance grants
    task automatic wr_single(input string tag, input logic [N-1:0] exp_rr, input logic [N-1:0] exp_fp);
        tick();
        check({tag, " rr"}, 64'(o_awready[0]), 64'(exp_rr));
        check({tag, " fp"}, 64'(o_awready[1]), 64'(exp_fp));
        tick();
        tick();
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin : stim
        logic [N-1:0] exp_oh;
        int unsigned  exp_h;

        // Reset: every valid/ready held low even with all inputs active
        rst = 1'b1;
        clear_inputs();
        up_awvalid = '1; up_arvalid = '1; up_wvalid = '1; up_bready = '1; up_rready = '1;
        ds_awready = 1'b1; ds_wready = 1'b1; ds_bvalid = 1'b1; ds_arready = 1'b1; ds_rvalid = 1'b1;
        tick();
        check("rst up", 64'({o_awready[0], o_wready[0], o_bvalid[0], o_arready[0], o_rvalid[0]}), 64'(0));
        check("rst ds", 64'({o_ds_awvalid[0], o_ds_wvalid[0], o_ds_bready[0], o_ds_arvalid[0], o_ds_rready[0]}), 64'(0));
        reset_dut();

        // 1: hosts 1 and 3 AW len=3 together
        up_awvalid = 4'b1010;
        for (int h = 0; h < 4; h++) begin
            up_awaddr[h*A +: A] = A'(h * 32'h100);
            up_awlen[h*8 +: 8]  = 8'd3;
            up_awid[h*I +: I]   = I'(h);
        end
        ds_awready = 1'b1; ds_wready = 1'b1;
        #1 check("t1 idle awvalid", 64'(o_ds_awvalid[0]), 64'(0));
        tick();
        check("t1 awvalid", 64'(o_ds_awvalid[0]), 64'(1));
        check("t1 awready h1", 64'(o_awready[0]), 64'(4'b0010));
        check("t1 awaddr", 64'(o_ds_awaddr[0]), 64'h100);
        check("t1 awlen", 64'(o_ds_awlen[0]), 64'(3));
        check("t1 awid", 64'(o_ds_awid[0]), 64'(1));
        tick();
        up_awvalid = 4'b1000;
        up_wvalid  = 4'b1010;
        up_wdata[3*D +: D] = 32'hDEAD_0003;
        for (int b = 0; b < 4; b++) begin
            up_wdata[1*D +: D] = 32'hA000_0000 + 32'(b);
            up_wlast = (b == 3) ? 4'b0010 : 4'b0000;
            #1;
            check("t1 wdata", 64'(o_ds_wdata[0]), 64'(32'hA000_0000 + 32'(b)));
            check("t1 wready", 64'(o_wready[0]), 64'(4'b0010));
            tick();
        end
        up_wvalid = '0; up_wlast = '0;
        ds_bvalid = 1'b1; ds_bresp = 2'b10; ds_bid = 4'd1; up_bready = 4'b1010;
        #1;
        check("t1 bvalid h1", 64'(o_bvalid[0]), 64'(4'b0010));
        check("t1 bready", 64'(o_ds_bready[0]), 64'(1));
        check("t1 bresp bcast", 64'(o_bresp[0]), 64'hAA);
        check("t1 bid bcast", 64'(o_bid[0]), 64'h1111);
        tick();
        check("t1 idle bvalid", 64'(o_bvalid[0]), 64'(0));
        tick();
        check("t1 awready h3", 64'(o_awready[0]), 64'(4'b1000));
        check("t1 awaddr h3", 64'(o_ds_awaddr[0]), 64'h300);
        tick();
        up_awvalid = '0;
        up_wvalid = 4'b1000; up_wlast = 4'b1000;
        #1 check("t1 h1 no bvalid", 64'(o_bvalid[0]), 64'(0));
        tick();
        check("t1 bvalid h3", 64'(o_bvalid[0]), 64'(4'b1000));
        tick();

        // 2: all hosts AR continuously, len=0
        reset_dut();
        up_arvalid = 4'hF;
        for (int h = 0; h < 4; h++) begin
            up_araddr[h*A +: A] = A'(32'h1000 + 32'(h) * 32'h10);
        end
        ds_arready = 1'b1; up_rready = 4'hF; ds_rlast = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_h  = k % 4;
            exp_oh = N'(1) << exp_h;
            tick();
            check("t2 arready", 64'(o_arready[0]), 64'(exp_oh));
            check("t2 araddr", 64'(o_ds_araddr[0]), 64'(32'h1000 + exp_h * 32'h10));
            tick();
            ds_rvalid = 1'b1; ds_rdata = 32'h5000_0000 + 32'(k);
            #1;
            check("t2 rvalid", 64'(o_rvalid[0]), 64'(exp_oh));
            check("t2 rdata", 64'(o_rdata[0][exp_h*D +: D]), 64'(32'h5000_0000 + 32'(k)));
            tick();
            ds_rvalid = 1'b0;
        end

        // 3: hosts 0 and 2 repeat; fixed priority keeps host 0
        reset_dut();
        up_awvalid = 4'b0101;
        ds_awready = 1'b1; ds_wready = 1'b1; ds_bvalid = 1'b1;
        up_wvalid = 4'hF; up_wlast = 4'hF; up_bready = 4'hF;
        wr_single("t3 r1", 4'b0001, 4'b0001);
        wr_single("t3 r2", 4'b0100, 4'b0001);
        wr_single("t3 r3", 4'b0001, 4'b0001);
        up_awvalid = 4'b0100;
        wr_single("t3 r4", 4'b0100, 4'b0100);

        // 4+5: host 0 AW len=7 with host 1 AR len=2; write stalls mid-burst
        reset_dut();
        up_awvalid = 4'b0001; up_awlen[7:0] = 8'd7; up_awaddr[A-1:0] = A'(32'h4000);
        up_arvalid = 4'b0010; up_arlen[15:8] = 8'd2; up_araddr[A +: A] = A'(32'h8000);
        ds_awready = 1'b1; ds_arready = 1'b1; ds_wready = 1'b0;
        tick();
        check("t4 both valid", 64'({o_ds_awvalid[0], o_ds_arvalid[0]}), 64'(2'b11));
        check("t4 araddr", 64'(o_ds_araddr[0]), 64'h8000);
        tick();
        up_awvalid = '0; up_arvalid = '0;
        up_wvalid = 4'b0001; up_rready = 4'b0010; ds_rvalid = 1'b1;
        up_wdata[D-1:0] = 32'hB000_0000;
        for (int b = 0; b < 3; b++) begin
            ds_rdata = 32'h7000 + 32'(b); ds_rlast = (b == 2);
            #1;
            check("t4 rvalid h1", 64'(o_rvalid[0]), 64'(4'b0010));
            check("t4 write waits", 64'(o_wready[0]), 64'(0));
            tick();
        end
        check("t4 read done", 64'({o_rvalid[0], o_ds_rready[0]}), 64'(0));
        ds_rvalid = 1'b0; ds_wready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            up_wdata[D-1:0] = 32'hB000_0000 + 32'(b);
            up_wlast = (b == 7) ? 4'b0001 : 4'b0000;
            if (b == 3) begin
                ds_wready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    check("t5 stall wready", 64'(o_wready[0]), 64'(0));
                    check("t5 stall hold", 64'({o_ds_wvalid[0], o_ds_wdata[0]}), 64'({1'b1, 32'hB000_0003}));
                    tick();
                end
                ds_wready = 1'b1;
            end
            #1;
            check("t5 wdata", 64'(o_ds_wdata[0]), 64'(32'hB000_0000 + 32'(b)));
            check("t5 wready", 64'(o_wready[0]), 64'(4'b0001));
            tick();
        end
        up_wvalid = '0; up_wlast = '0;
        ds_bvalid = 1'b1; up_bready = 4'b0001;
        #1 check("t5 bvalid h0", 64'(o_bvalid[0]), 64'(4'b0001));
        tick();
        ds_bvalid = 1'b0;

        // 6: reset during W_DATA beat 2 of host 2's burst
        up_awvalid = 4'b0100; up_awlen[23:16] = 8'd3;
        ds_awready = 1'b1; ds_wready = 1'b1;
        tick();
        check("t6 awready h2", 64'(o_awready[0]), 64'(4'b0100));
        tick();
        up_awvalid = '0; up_wvalid = 4'b0100;
        tick();
        tick();
        ds_bvalid = 1'b1; ds_rvalid = 1'b1; ds_arready = 1'b1; up_arvalid = 4'hF; up_rready = 4'hF; up_bready = 4'hF;
        #1 check("t6 pre-rst wvalid", 64'(o_ds_wvalid[0]), 64'(1));
        rst = 1'b1;
        #1;
        check("t6 rst up", 64'({o_awready[0], o_wready[0], o_bvalid[0], o_arready[0], o_rvalid[0]}), 64'(0));
        check("t6 rst ds", 64'({o_ds_awvalid[0], o_ds_wvalid[0], o_ds_bready[0], o_ds_arvalid[0], o_ds_rready[0]}), 64'(0));
        tick();
        clear_inputs();
        rst = 1'b0;
        up_awvalid = 4'hF; up_arvalid = 4'hF;
        tick();
        check("t6 w ptr zero", 64'(o_awready[0]), 64'(0));
        check("t6 idle grant aw", 64'(o_ds_awaddr[0]), 64'(0));
        ds_awready = 1'b1; ds_arready = 1'b1;
        #1;
        check("t6 aw host0", 64'(o_awready[0]), 64'(4'b0001));
        check("t6 ar host0", 64'(o_arready[0]), 64'(4'b0001));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
